// File: rtl/fixed_p_std_mult_arb.sv
// Round-robin shared unsigned fixed-point multiplier with Calyx go/done handshake per requester.
// Optional build macro FIXED_P_MULT_ARB_SAT_EN saturates integer overflow instead of wrapping.
module fixed_p_std_mult_arb #(
   parameter int width       = 32,
   parameter int int_width   = 8,
   parameter int fract_width = 24,
   parameter int n_req       = 2,
   parameter int latency     = 3
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [n_req-1:0]         go,
   input  logic [n_req*width-1:0]   left,
   input  logic [n_req*width-1:0]   right,
   output logic [width-1:0]         out,
   output logic [n_req-1:0]         done,
   output logic                     busy
);

   localparam int PW = (n_req > 1) ? $clog2(n_req) : 1;
   localparam int CW = (latency > 1) ? $clog2(latency) : 1;

   if (int_width + fract_width != width) begin : g_param_err
      $error("fixed_p_std_mult_arb: int_width + fract_width must equal width");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_DONE
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [PW-1:0]         r_ptr;
   logic [PW-1:0]         r_gnt;
   logic [PW-1:0]         w_sel;
   logic [CW-1:0]         r_cnt;
   logic [width-1:0]      r_op_l;
   logic [width-1:0]      r_op_r;
   logic [width-1:0]      r_out;
   logic [2*width-1:0]    w_prod;
   logic                  w_start;

   function automatic logic [width-1:0] f_scale(input logic [2*width-1:0] p);
      logic [width-1:0] res;
      res = p[width+fract_width-1 : fract_width];
`ifdef FIXED_P_MULT_ARB_SAT_EN
      if (p[2*width-1 : width+fract_width] != '0) res = '1;
`endif
      return res;
   endfunction

   // Lowest-distance requester after the last grant wins; scanning from far to near keeps the nearest.
   always_comb begin
      w_sel = r_ptr;
      for (int k = n_req; k >= 1; k--) begin
         if (go[(int'(r_ptr) + k) % n_req]) w_sel = PW'((int'(r_ptr) + k) % n_req);
      end
   end

   assign w_start = (r_state == S_IDLE) && (|go);
   assign w_prod  = (2*width)'(r_op_l) * (2*width)'(r_op_r);

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE:  if (|go) w_state_nxt = S_BUSY;
         S_BUSY:  if (r_cnt == '0) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ptr <= PW'(n_req - 1);
         r_gnt <= '0;
         r_cnt <= '0;
         r_out <= '0;
      end else begin
         if (w_start) begin
            r_gnt <= w_sel;
            r_ptr <= w_sel;
            r_cnt <= CW'(latency - 1);
         end else if (r_state == S_BUSY && r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
         end
         if (r_state == S_BUSY && r_cnt == '0) r_out <= f_scale(w_prod);
      end
   end

   // Operands are frozen at grant so requesters may change their buses while BUSY.
   always_ff @(posedge clk) begin
      if (w_start) begin
         r_op_l <= left[int'(w_sel)*width +: width];
         r_op_r <= right[int'(w_sel)*width +: width];
      end
   end

   always_comb begin
      done = '0;
      if (r_state == S_DONE) done[r_gnt] = 1'b1;
   end

   assign busy = (r_state != S_IDLE);
   assign out  = r_out;

endmodule

// File: tb/tb_fixed_p_std_mult_arb.sv
// Scoreboard bench for fixed_p_std_mult_arb: directed scenarios followed by random traffic.
module tb_fixed_p_std_mult_arb;

   localparam int W   = 32;
   localparam int IW  = 8;
   localparam int F   = 24;
   localparam int N   = 2;
   localparam int LAT = 3;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [N-1:0]     go = '0;
   logic [N*W-1:0]   left = '0;
   logic [N*W-1:0]   right = '0;
   logic [W-1:0]     out;
   logic [N-1:0]     done;
   logic             busy;

   always #5 clk = ~clk;

   fixed_p_std_mult_arb #(
      .width(W), .int_width(IW), .fract_width(F), .n_req(N), .latency(LAT)
   ) dut (
      .clk(clk), .reset(reset), .go(go), .left(left), .right(right),
      .out(out), .done(done), .busy(busy)
   );

   typedef struct {
      int          req;
      logic [W-1:0] val;
      int          due;
   } exp_t;

   exp_t exp_q[$];
   int   cyc = 0;
   int   rst_cnt = 0;
   int   errors = 0;
   int   checks = 0;
   int   m_free = 0;
   int   m_busy_until = -100;
   int   m_ptr = N - 1;

   function automatic logic [W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [2*W-1:0] p;
      p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
`ifdef FIXED_P_MULT_ARB_SAT_EN
      if ((p >> (W + F)) != '0) return '1;
`endif
      return p[W+F-1:F];
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, expv);
      end
   endtask

   // Reference model: one op at a time, round-robin from the last grant, done LAT cycles after grant.
   initial begin
      int g;
      forever begin
         @(posedge clk);
         cyc++;
         if (reset) begin
            exp_q.delete();
            m_ptr = N - 1;
            m_free = cyc + 1;
            m_busy_until = cyc - 1;
            rst_cnt++;
         end else if (cyc >= m_free && go != '0) begin
            g = -1;
            for (int k = 1; k <= N; k++)
               if (g < 0 && go[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            exp_q.push_back('{g, ref_mul(left[g*W +: W], right[g*W +: W]), cyc + LAT});
            m_ptr = g;
            m_free = cyc + LAT + 2;
            m_busy_until = cyc + LAT;
         end
      end
   end

   // Monitor: samples on the falling edge.
   initial begin
      logic [W-1:0] held;
      logic [N-1:0] exp_done;
      exp_t         e;
      int           seen_rst;
      held = '0;
      seen_rst = 0;
      wait (rst_cnt > 0);
      forever begin
         @(negedge clk);
         if (rst_cnt != seen_rst) begin
            held = '0;
            seen_rst = rst_cnt;
         end
         chk("busy", 64'(busy), 64'(cyc <= m_busy_until));
         chk("done_onehot", 64'($onehot0(done)), 64'd1);
         if (done != '0) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_done", 64'(done), 64'd0);
            end else begin
               e = exp_q.pop_front();
               exp_done = '0;
               exp_done[e.req] = 1'b1;
               chk("done_req", 64'(done), 64'(exp_done));
               chk("out", 64'(out), 64'(e.val));
               chk("done_cycle", 64'(cyc), 64'(e.due));
               held = e.val;
            end
         end else begin
            chk("out_hold", 64'(out), 64'(held));
            if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
               e = exp_q.pop_front();
               chk("missing_done", 64'(cyc), 64'(e.due));
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
      left[i*W +: W] = a;
      right[i*W +: W] = b;
      go[i] = 1'b1;
   endtask

   task automatic wait_done(input logic [N-1:0] mask, output int idx);
      idx = -1;
      for (int t = 0; t < 60; t++) begin
         for (int i = 0; i < N; i++)
            if (idx < 0 && mask[i] && done[i]) idx = i;
         if (idx >= 0) break;
         tick();
      end
      chk("done_timeout", 64'(idx >= 0), 64'd1);
   endtask

   function automatic logic [W-1:0] rnd_op();
      case ($urandom % 6)
         0:       return '0;
         1:       return '1;
         default: return W'($urandom);
      endcase
   endfunction

   initial begin
      int idx;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tick();

      // 1.5 * 2.0 on requester 0
      set_req(0, 32'h0180_0000, 32'h0200_0000);
      wait_done(2'b01, idx);
      go[0] = 1'b0;
      tick();

      // Both requesters held high: grants alternate
      set_req(0, rnd_op(), rnd_op());
      set_req(1, rnd_op(), rnd_op());
      for (int k = 0; k < 4; k++) begin
         wait_done(2'b11, idx);
         if (k == 3) go = '0;
         else if (idx >= 0) set_req(idx, rnd_op(), rnd_op());
         tick();
      end

      // Integer overflow
      set_req(1, 32'h8000_0000, 32'h0200_0000);
      wait_done(2'b10, idx);
      go[1] = 1'b0;
      tick();

      // Inputs change while BUSY
      set_req(0, 32'h00C0_0000, 32'h0040_0000);
      tick();
      left = {$urandom, $urandom};
      right = {$urandom, $urandom};
      go[0] = 1'b0;
      wait_done(2'b01, idx);
      tick();

      // Reset in the second BUSY cycle, then both request: req0 first
      set_req(0, 32'h0100_0000, 32'h0300_0000);
      tick();
      tick();
      reset = 1'b1;
      go = '0;
      tick();
      reset = 1'b0;
      set_req(0, 32'h0280_0000, 32'h0200_0000);
      set_req(1, 32'h0040_0000, 32'h0800_0000);
      wait_done(2'b01, idx);
      go[0] = 1'b0;
      tick();
      wait_done(2'b10, idx);
      go[1] = 1'b0;
      tick();

      // Fraction truncation, then idle hold
      set_req(1, 32'h0000_0001, 32'h0000_0001);
      wait_done(2'b10, idx);
      go[1] = 1'b0;
      repeat (6) tick();

      // Random traffic
      for (int t = 0; t < 400; t++) begin
         for (int i = 0; i < N; i++) begin
            if (go[i] && done[i]) begin
               if ($urandom % 2 == 0) go[i] = 1'b0;
               else set_req(i, rnd_op(), rnd_op());
            end else if (!go[i] && ($urandom % 3 == 0)) begin
               set_req(i, rnd_op(), rnd_op());
            end
         end
         tick();
      end
      go = '0;
      repeat (LAT + 5) tick();
      chk("queue_empty", 64'(exp_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
